// File: rtl/alu_seq_pkg.sv
// Shared constants for the chunked Y86 ALU sequencer: ifun codes, FSM state encoding
// and the ifun legality helper.
package alu_seq_pkg;

  // Y86 OPq function codes
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  // Sequencer FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Only the four OPq function codes are executable
  function automatic logic ifun_valid(input logic [3:0] ifun);
    return (ifun <= ALU_XOR);
  endfunction

endpackage

// File: rtl/alu_chunk_slice.sv
// One CHUNK_W-bit ALU slice: add with carry in/out, and, xor. Purely combinational.
// b_inv_i complements the valA operand so that valB + ~valA + cin forms valB - valA.
module alu_chunk_slice
  import alu_seq_pkg::*;
#(
  parameter int unsigned CHUNK_W = 16
) (
  input  logic [1:0]         op_i,
  input  logic               b_inv_i,
  input  logic [CHUNK_W-1:0] a_i,
  input  logic [CHUNK_W-1:0] b_i,
  input  logic               cin_i,
  output logic [CHUNK_W-1:0] r_o,
  output logic               cout_o
);

  logic [CHUNK_W-1:0] a_eff;
  logic [CHUNK_W:0]   sum;

  // Select the slice function; logic ops never produce a carry
  always_comb begin
    a_eff  = b_inv_i ? ~a_i : a_i;
    sum    = {1'b0, b_i} + {1'b0, a_eff} + {{CHUNK_W{1'b0}}, cin_i};
    r_o    = sum[CHUNK_W-1:0];
    cout_o = sum[CHUNK_W];
    if (op_i == ALU_AND[1:0]) begin
      r_o    = a_i & b_i;
      cout_o = 1'b0;
    end else if (op_i == ALU_XOR[1:0]) begin
      r_o    = a_i ^ b_i;
      cout_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_chunk_sequencer.sv
// Multi-cycle Y86 OPq unit: sequences one CHUNK_W-bit slice over DATA_W-bit operands,
// LSB chunk first, with valid/ready on both request and response sides.
// Optional feature macro: ALU_SEQ_CC_EN builds the ZF/SF/OF condition-code logic;
// without it the flag outputs are tied low.
module alu_chunk_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned CHUNK_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        req_ifun_i,
  input  logic [DATA_W-1:0] req_vala_i,
  input  logic [DATA_W-1:0] req_valb_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_result_o,
  output logic              resp_zf_o,
  output logic              resp_sf_o,
  output logic              resp_of_o,
  output logic              resp_err_o,
  output logic              busy_o
);

  localparam int unsigned NCHUNK = DATA_W / CHUNK_W;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [3:0]        ifun_q, ifun_d;
  logic [DATA_W-1:0] a_sh_q, a_sh_d;
  logic [DATA_W-1:0] b_sh_q, b_sh_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q, err_d;

  logic               accept;
  logic               is_sub;
  logic               last_chunk;
  logic               slice_cin;
  logic [CHUNK_W-1:0] slice_r;
  logic               slice_cout;

  assign req_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign resp_valid_o  = (state_q == DONE);
  assign resp_result_o = result_q;
  assign resp_err_o    = err_q;

  assign accept     = req_valid_i & req_ready_o;
  assign is_sub     = (ifun_q == ALU_SUB);
  assign last_chunk = (cnt_q == LAST_CHUNK);
  // SUB injects the +1 of two's complement as carry-in on the first chunk only
  assign slice_cin  = (cnt_q == '0) ? is_sub : carry_q;

  alu_chunk_slice #(
    .CHUNK_W (CHUNK_W)
  ) u_slice (
    .op_i    (ifun_q[1:0]),
    .b_inv_i (is_sub),
    .a_i     (a_sh_q[CHUNK_W-1:0]),
    .b_i     (b_sh_q[CHUNK_W-1:0]),
    .cin_i   (slice_cin),
    .r_o     (slice_r),
    .cout_o  (slice_cout)
  );

  // FSM, chunk counter, operand shifters and result assembly
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    ifun_d   = ifun_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ifun_d   = req_ifun_i;
          a_sh_d   = req_vala_i;
          b_sh_d   = req_valb_i;
          result_d = '0;
          cnt_d    = '0;
          carry_d  = 1'b0;
          err_d    = ~ifun_valid(req_ifun_i);
          state_d  = ifun_valid(req_ifun_i) ? RUN : DONE;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < NCHUNK; i++) begin
          if (cnt_q == CNT_W'(i)) result_d[i*CHUNK_W +: CHUNK_W] = slice_r;
        end
        carry_d = slice_cout;
        a_sh_d  = a_sh_q >> CHUNK_W;
        b_sh_d  = b_sh_q >> CHUNK_W;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_chunk) begin
          // MSB carry-out is simply dropped: 64-bit wrap-around
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      ifun_q   <= ALU_ADD;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      ifun_q   <= ifun_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

`ifdef ALU_SEQ_CC_EN
  logic zero_q, zero_d;
  logic zf_q, zf_d;
  logic sf_q, sf_d;
  logic of_q, of_d;
  logic a_msb, b_msb, r_msb, chunk_zero;

  // On the last chunk the low slice bits of the shifters hold the operand MSBs
  assign a_msb      = a_sh_q[CHUNK_W-1];
  assign b_msb      = b_sh_q[CHUNK_W-1];
  assign r_msb      = slice_r[CHUNK_W-1];
  assign chunk_zero = (slice_r == '0);

  // Running zero bit across chunks; flags latch on the RUN->DONE edge
  always_comb begin
    zero_d = zero_q;
    zf_d   = zf_q;
    sf_d   = sf_q;
    of_d   = of_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          zero_d = 1'b1;
          zf_d   = 1'b0;
          sf_d   = 1'b0;
          of_d   = 1'b0;
        end
      end
      RUN: begin
        zero_d = zero_q & chunk_zero;
        if (last_chunk) begin
          zf_d = zero_q & chunk_zero;
          sf_d = r_msb;
          case (ifun_q)
            ALU_ADD: of_d = (a_msb == b_msb) && (r_msb != b_msb);
            ALU_SUB: of_d = (a_msb != b_msb) && (r_msb != b_msb);
            default: of_d = 1'b0;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Condition-code state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      zf_q   <= 1'b0;
      sf_q   <= 1'b0;
      of_q   <= 1'b0;
    end else begin
      zero_q <= zero_d;
      zf_q   <= zf_d;
      sf_q   <= sf_d;
      of_q   <= of_d;
    end
  end

  assign resp_zf_o = zf_q;
  assign resp_sf_o = sf_q;
  assign resp_of_o = of_q;
`else
  assign resp_zf_o = 1'b0;
  assign resp_sf_o = 1'b0;
  assign resp_of_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_chunk_sequencer.sv
// Self-checking bench for alu_chunk_sequencer: transaction-level reference model,
// per-cycle compare process, directed corner cases and a randomized phase.
module tb_alu_chunk_sequencer;

  localparam int NCHUNK = 4;
`ifdef ALU_SEQ_CC_EN
  localparam bit CC = 1'b1;
`else
  localparam bit CC = 1'b0;
`endif

  typedef struct packed {
    logic        e;
    logic        o;
    logic        s;
    logic        z;
    logic [63:0] r;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_ifun;
  logic [63:0] req_vala;
  logic [63:0] req_valb;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_result;
  logic        resp_zf, resp_sf, resp_of, resp_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_chunk_sequencer #(
    .DATA_W  (64),
    .CHUNK_W (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_ifun_i    (req_ifun),
    .req_vala_i    (req_vala),
    .req_valb_i    (req_valb),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_result_o (resp_result),
    .resp_zf_o     (resp_zf),
    .resp_sf_o     (resp_sf),
    .resp_of_o     (resp_of),
    .resp_err_o    (resp_err),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural result of one OPq, straight from the Y86 definition
  function automatic exp_t ref_op(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
    exp_t x;
    x = '0;
    case (f)
      4'd0: x.r = b + a;
      4'd1: x.r = b - a;
      4'd2: x.r = a & b;
      4'd3: x.r = a ^ b;
      default: x.e = 1'b1;
    endcase
    if (CC && !x.e) begin
      x.z = (x.r == 64'd0);
      x.s = x.r[63];
      if (f == 4'd0) x.o = (a[63] == b[63]) && (x.r[63] != b[63]);
      if (f == 4'd1) x.o = (a[63] != b[63]) && (x.r[63] != b[63]);
    end
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding op, visible NCHUNK edges after accept (invalid: at once)
  bit   m_pend = 1'b0;
  int   m_wait = 0;
  exp_t m_exp  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      m_wait <= 0;
    end else if (!m_pend) begin
      if (req_valid) begin
        m_pend <= 1'b1;
        m_wait <= (req_ifun <= 4'd3) ? NCHUNK : 0;
        m_exp  <= ref_op(req_ifun, req_vala, req_valb);
      end
    end else if (m_wait != 0) begin
      m_wait <= m_wait - 1;
    end else if (resp_ready) begin
      m_pend <= 1'b0;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", {63'd0, req_ready}, 64'd1);
      chk("rst_valid", {63'd0, resp_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_result", resp_result, 64'd0);
      chk("rst_flags", {60'd0, resp_zf, resp_sf, resp_of, resp_err}, 64'd0);
    end else begin
      chk("cyc_ready", {63'd0, req_ready}, {63'd0, !m_pend});
      chk("cyc_busy", {63'd0, busy}, {63'd0, m_pend});
      chk("cyc_valid", {63'd0, resp_valid}, {63'd0, m_pend && m_wait == 0});
      if (m_pend && m_wait == 0) begin
        chk("cyc_result", resp_result, m_exp.r);
        chk("cyc_flags", {60'd0, resp_zf, resp_sf, resp_of, resp_err},
            {60'd0, m_exp.z, m_exp.s, m_exp.o, m_exp.e});
      end
    end
  end

  // Directed op with literal expectations; optional DONE hold with a blocked second request
  task automatic run_op(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] er, input logic ez, input logic es, input logic eo,
                        input logic ee, input int hold, input bit probe);
    int guard;
    int lat;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("idle_before_op", {63'd0, req_ready}, 64'd1);
    resp_ready = (hold == 0);
    req_valid  = 1'b1;
    req_ifun   = f;
    req_vala   = a;
    req_valb   = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_vala  = {$urandom, $urandom};
    req_valb  = {$urandom, $urandom};
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), (f <= 4'd3) ? 64'(NCHUNK) : 64'd0);
    chk("op_result", resp_result, er);
    chk("op_flags", {60'd0, resp_zf, resp_sf, resp_of, resp_err}, {60'd0, ez, es, eo, ee});
    for (int k = 0; k < hold; k++) begin
      if (probe) begin
        req_valid = 1'b1;
        req_ifun  = 4'd0;
      end
      @(posedge clk); #1;
      chk("hold_valid", {63'd0, resp_valid}, 64'd1);
      chk("hold_ready", {63'd0, req_ready}, 64'd0);
      chk("hold_result", resp_result, er);
      chk("hold_flags", {60'd0, resp_zf, resp_sf, resp_of, resp_err}, {60'd0, ez, es, eo, ee});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("post_valid", {63'd0, resp_valid}, 64'd0);
    chk("post_ready", {63'd0, req_ready}, 64'd1);
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'($urandom_range(0, 100));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        x;
    logic [63:0] v;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_ifun   = 4'd0;
    req_vala   = '0;
    req_valb   = '0;
    resp_ready = 1'b1;

    // Pin the model against hand-computed values
    x = ref_op(4'd0, 64'd1, 64'd2);
    chk("model_add", {x.e, x.o, x.s, x.z, x.r[59:0]}, 64'd3);
    x = ref_op(4'd1, 64'd1, 64'h1_0000);
    chk("model_sub", x.r, 64'hFFFF);
    x = ref_op(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("model_ovf", {x.e, x.o, x.s, x.z, x.r[59:0]},
        {1'b0, CC, CC, 1'b0, 60'hFFF_FFFF_FFFF_FFFE});

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(4'd0, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op(4'd1, 64'd1, 64'h1_0000, 64'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op(4'd1, 64'd5, 64'd5, 64'd0, CC, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE,
           1'b0, CC, CC, 1'b0, 0, 1'b0);
    v = {$urandom, $urandom} | 64'h8000_0000_0000_0001;
    run_op(4'd3, v, v, 64'd0, CC, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op(4'd2, 64'hF0F0_1234_0000_FFFF, 64'h0FF0_FF00_FFFF_00F0, 64'h00F0_1200_0000_00F0,
           1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    // DONE held for 3 cycles with a competing request on the bus
    run_op(4'd1, 64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, CC, 1'b0, 1'b0, 3, 1'b1);

    // Reset while chunk 2 is in flight
    req_valid = 1'b1;
    req_ifun  = 4'd0;
    req_vala  = 64'h1111_2222_3333_4444;
    req_valb  = 64'h5555_6666_7777_8888;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ready", {63'd0, req_ready}, 64'd1);
    chk("async_valid", {63'd0, resp_valid}, 64'd0);
    chk("async_busy", {63'd0, busy}, 64'd0);
    chk("async_result", resp_result, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(4'd0, 64'd7, 64'd8, 64'd15, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Illegal function codes
    run_op(4'd4, 64'd9, 64'd9, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    run_op(4'd15, 64'hFFFF, 64'd1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);

    // Randomized traffic; the compare process does the checking
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      req_valid  = ($urandom_range(0, 2) != 0);
      req_ifun   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15))
                                               : 4'($urandom_range(0, 3));
      req_vala   = pick_operand();
      req_valb   = ($urandom_range(0, 5) == 0) ? req_vala : pick_operand();
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    repeat (NCHUNK + 3) @(posedge clk);
    #1;
    chk("drain_idle", {63'd0, req_ready}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
